seq_divider: RTL
================

# seq_divider

Multi-cycle radix-2 restoring divider that serves the execute-stage ALU's divide requests (DIV/DIVU). It accepts a start request with two 32-bit operands and a signedness flag, iterates one quotient bit per cycle, and returns `{remainder, quotient}` with a one-cycle ready pulse. Ready releases the ALU's pipeline stall. The ALU writes HI from the remainder and LO from the quotient.

## Interface
- `WIDTH`, 32, operand width; result is `2*WIDTH`.
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `signed_div` in 1: 1 = two's-complement divide, 0 = unsigned. Captured with the start request.
- `opdata1` in WIDTH: dividend (rs).
- `opdata2` in WIDTH: divisor (rt).
- `start` in 1: request. Held high by the ALU until `ready` is seen.
- `annul` in 1: abort the current operation (pipeline flush or clear).
- `result` out 2*WIDTH: `{remainder[WIDTH-1:0], quotient[WIDTH-1:0]}`.
- `ready` out 1: result valid. High for exactly one cycle.

## Operation
- States: IDLE, DIVZERO, ON, END.
- **IDLE**
  - On `start=1` and `annul=0`: latch `opdata1`, `opdata2` and `signed_div`.
  - If the divisor is 0, go to DIVZERO. Otherwise go to ON with the iteration counter at 0.
- **Magnitudes:** in signed mode, negative operands are negated to their magnitudes at latch time. Latched operands are immune to later input changes.
- **ON:** one restoring step per cycle.
  - Shift the partial remainder left and bring in the next dividend bit.
  - Trial-subtract the divisor magnitude. On non-negative, keep the difference and set the quotient bit to 1; otherwise restore and set 0.
  - After the step with counter = WIDTH-1, go to END.
- **DIVZERO:** result forced to 0; go to END next cycle.
- **END**
  - `ready=1` and `result` valid.
  - Signed fix-up is applied when forming `result`: quotient negated if `sign(a)^sign(b)`; remainder takes the sign of the dividend.
  - Always go to IDLE next cycle. `start` is ignored in END.
- **Overflow case:** `-2^31 / -1` (signed) gives quotient `0x80000000` (wraps) and remainder 0, with no flag.
- **Result hold:** `result` holds its END value after `ready` falls, until the next accepted start or `annul`.
- **Annul:** `annul=1` in any state sends the FSM to IDLE next cycle, drives `ready=0` and clears `result` to 0. No ready pulse is produced for the aborted operation.
- **annul and start together:** annul wins; the start is not accepted.
- **Reset:** `rst=1` gives state IDLE, counter 0, `result=0`, `ready=0`. Reset has priority over annul and start.

## Timing
- Start is sampled in IDLE at edge 0.
- Normal divide: ON occupies cycles 1..WIDTH; `ready` is high in cycle WIDTH+1 (33 for WIDTH=32).
- Divide by zero: `ready` is high in cycle 2.
- `ready` and `result` are registered state decodes, so they are valid at the start of the END cycle. The ALU may use them combinationally to drop `start` and the stall in that cycle.
- A back-to-back start is accepted at the earliest in the cycle after END, when the FSM is in IDLE.

## Configuration
- **`SEQ_DIV_EARLY_EXIT_EN` defined:**
  - In IDLE, if the divisor is nonzero and the dividend magnitude is less than the divisor magnitude, take the DIVZERO-style short path.
  - The raw result is quotient 0 and remainder = dividend magnitude, with the normal sign fix-up; `ready` is high in cycle 2.
- **Not defined:** every nonzero-divisor operation runs the full WIDTH iterations, so `ready` is high in cycle 33. Results are identical either way; only latency differs.

## Test plan
- **Unsigned 100/7:** `opdata1=100`, `opdata2=7`, `signed_div=0`.
  - Required: `result={32'd2, 32'd14}`, `ready` high only in cycle 33.
  - Required: `result` is unchanged after ready falls.
- **Signed -7/2:** `opdata1=0xFFFFFFF9`, `opdata2=2`, `signed_div=1`.
  - Required: quotient `0xFFFFFFFD`, remainder `0xFFFFFFFF`.
  - Required: the same operands with `signed_div=0` give quotient `0x7FFFFFFC`, remainder 1.
- **Divide by zero:** `5/0` in either mode. Required: `result=0`, `ready` in cycle 2.
- **Overflow case:** `0x80000000 / 0xFFFFFFFF` signed. Required: quotient `0x80000000`, remainder 0, `ready` in cycle 33.
- **Annul mid-operation:** assert `annul` in cycle 10 of a divide.
  - Required: next cycle is IDLE with `result=0`, and no ready pulse occurs.
  - Required: a following `100/7` completes correctly.
  - Required: `rst` asserted in cycle 10 behaves the same.
- **Early exit, 3/10 unsigned:** with `SEQ_DIV_EARLY_EXIT_EN`, `result={32'd3, 32'd0}` with `ready` in cycle 2. Without the macro, the same result with `ready` in cycle 33.

Source files
------------

// File: rtl/seq_divider_if.sv
// -----------------------------------------------------------------------------
// seq_divider_if
// Request/response bundle between the execute-stage ALU and seq_divider.
//   signed_div : 1 = two's-complement divide, 0 = unsigned (ALU -> divider)
//   opdata1    : dividend (rs)                              (ALU -> divider)
//   opdata2    : divisor  (rt)                              (ALU -> divider)
//   start      : request, held until ready is seen          (ALU -> divider)
//   annul      : abort current operation                    (ALU -> divider)
//   result     : {remainder, quotient}                      (divider -> ALU)
//   ready      : one-cycle result-valid pulse               (divider -> ALU)
// Modports: master = ALU side, slave = divider side.
// -----------------------------------------------------------------------------
interface seq_divider_if #(
   parameter int WIDTH = 32
);
   logic                   signed_div;
   logic [WIDTH-1:0]       opdata1;
   logic [WIDTH-1:0]       opdata2;
   logic                   start;
   logic                   annul;
   logic [2*WIDTH-1:0]     result;
   logic                   ready;

   modport master (
      output signed_div, opdata1, opdata2, start, annul,
      input  result, ready
   );

   modport slave (
      input  signed_div, opdata1, opdata2, start, annul,
      output result, ready
   );
endinterface

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
// Multi-cycle radix-2 restoring divider for DIV/DIVU. One quotient bit is
// produced per cycle; the result {remainder, quotient} is presented with a
// one-cycle ready pulse and then held until the next accepted start or annul.
//
// Ports:
//   clk    : clock, rising edge
//   rst    : synchronous active-high reset (priority over annul and start)
//   div_if : seq_divider_if.slave (signed_div, opdata1, opdata2, start, annul
//            in; result, ready out)
//
// Optional build macro:
//   SEQ_DIV_EARLY_EXIT_EN : when defined, a nonzero divisor whose magnitude
//                           exceeds the dividend magnitude skips the iteration
//                           loop (quotient 0, remainder = dividend).
// -----------------------------------------------------------------------------
module seq_divider #(
   parameter int WIDTH = 32
) (
   input  logic          clk,
   input  logic          rst,
   seq_divider_if.slave  div_if
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_DIVZERO = 2'd1,
      S_ON      = 2'd2,
      S_END     = 2'd3
   } state_t;

   state_t               state_q;
   logic [CNT_W-1:0]     cnt_q;
   logic [WIDTH-1:0]     rem_q;      // partial remainder
   logic [WIDTH-1:0]     quo_q;      // dividend bits shift out, quotient bits shift in
   logic [WIDTH-1:0]     dvs_q;      // divisor magnitude
   logic                 neg_quo_q;
   logic                 neg_rem_q;
   logic [2*WIDTH-1:0]   result_q;
   logic                 ready_q;

   logic [WIDTH-1:0]     mag_a;
   logic [WIDTH-1:0]     mag_b;
   logic [WIDTH:0]       shifted;
   logic                 ge;
   logic [WIDTH-1:0]     rem_d;
   logic [WIDTH-1:0]     quo_d;

   // Two's-complement magnitude; -2^(W-1) maps to 2^(W-1) as an unsigned value.
   function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v,
                                                  input logic                     is_signed);
      logic [WIDTH-1:0] u;
      u = $unsigned(v);
      return (is_signed && v[WIDTH-1]) ? (~u + 1'b1) : u;
   endfunction

   // Sign restoration: quotient negated on differing operand signs,
   // remainder follows the dividend sign. Quotient wraps for -2^(W-1)/-1.
   function automatic logic [2*WIDTH-1:0] fixup(input logic [WIDTH-1:0] r,
                                               input logic [WIDTH-1:0] q,
                                               input logic             neg_r,
                                               input logic             neg_q);
      logic [WIDTH-1:0] r_f;
      logic [WIDTH-1:0] q_f;
      r_f = neg_r ? (~r + 1'b1) : r;
      q_f = neg_q ? (~q + 1'b1) : q;
      return {r_f, q_f};
   endfunction

   always_comb begin
      mag_a = magnitude(div_if.opdata1, div_if.signed_div);
      mag_b = magnitude(div_if.opdata2, div_if.signed_div);
   end

   // One restoring step. The true difference is always below the divisor when
   // it is kept, so the low WIDTH bits of the subtraction are exact.
   always_comb begin
      shifted = {rem_q, quo_q[WIDTH-1]};
      ge      = (shifted >= {1'b0, dvs_q});
      rem_d   = ge ? (shifted[WIDTH-1:0] - dvs_q) : shifted[WIDTH-1:0];
      quo_d   = {quo_q[WIDTH-2:0], ge};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         result_q <= '0;
         ready_q  <= 1'b0;
      end else if (div_if.annul) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         result_q <= '0;
         ready_q  <= 1'b0;
      end else begin
         ready_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (div_if.start) begin
                  result_q  <= '0;
                  dvs_q     <= mag_b;
                  neg_quo_q <= div_if.signed_div & (div_if.opdata1[WIDTH-1] ^ div_if.opdata2[WIDTH-1]);
                  neg_rem_q <= div_if.signed_div & div_if.opdata1[WIDTH-1];
                  cnt_q     <= '0;
                  if (div_if.opdata2 == '0) begin
                     // zero raw operands make the DIVZERO fix-up yield 0
                     rem_q   <= '0;
                     quo_q   <= '0;
                     state_q <= S_DIVZERO;
`ifdef SEQ_DIV_EARLY_EXIT_EN
                  end else if (mag_a < mag_b) begin
                     rem_q   <= mag_a;
                     quo_q   <= '0;
                     state_q <= S_DIVZERO;
`endif
                  end else begin
                     rem_q   <= '0;
                     quo_q   <= mag_a;
                     state_q <= S_ON;
                  end
               end
            end
            S_ON: begin
               rem_q <= rem_d;
               quo_q <= quo_d;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == CNT_LAST) begin
                  result_q <= fixup(rem_d, quo_d, neg_rem_q, neg_quo_q);
                  ready_q  <= 1'b1;
                  state_q  <= S_END;
               end
            end
            S_DIVZERO: begin
               result_q <= fixup(rem_q, quo_q, neg_rem_q, neg_quo_q);
               ready_q  <= 1'b1;
               state_q  <= S_END;
            end
            S_END: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign div_if.result = result_q;
   assign div_if.ready  = ready_q;

endmodule
